// File: rtl/mef_supervisor.sv
// mef_supervisor: supervisory sequencer above the main process FSM.
//
// Turns operator buttons into the main FSM's `start` enable, watches the
// main FSM state code and alarm, enforces a per-stage timeout, latches
// faults until acknowledged, and counts completed batches.
//
// Ports:
//   clock          system clock, rising edge
//   reset_n        asynchronous active-low reset
//   btn_liga       run / resume request (level)
//   btn_parar      pause request (level)
//   btn_reconhece  fault acknowledge / abort (level)
//   estado[2:0]    main FSM state code, 3'b000 = rest
//   alarme_in      main FSM alarm
//   start          main FSM enable, high only in ATIVO
//   falha          latched fault, high only in FALHA
//   timeout        fault cause is stage timeout (valid while falha=1)
//   lotes          completed batch count, saturating
//   sup_estado     supervisor state code (display / debug)
//
// Handshake note: there is no valid/ready traffic here. Buttons are
// levels; a press is the single-cycle rising edge, registered before the
// FSM consumes it, so a press reaches `start` two clock edges after the
// input rises.
module mef_supervisor #(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int TW             = 10,
  parameter int BATCH_W        = 4
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               btn_liga,
  input  logic               btn_parar,
  input  logic               btn_reconhece,
  input  logic [2:0]         estado,
  input  logic               alarme_in,
  output logic               start,
  output logic               falha,
  output logic               timeout,
  output logic [BATCH_W-1:0] lotes,
  output logic [2:0]         sup_estado
);

  typedef enum logic [2:0] {
    OCIOSO    = 3'b000,
    ATIVO     = 3'b001,
    PAUSA     = 3'b010,
    FALHA     = 3'b011,
    CONCLUIDO = 3'b100
  } sup_state_t;

  localparam logic [TW-1:0]      TLIM     = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [BATCH_W-1:0] LOTES_MX = '1;

  sup_state_t    state;
  logic [TW-1:0] timer;
  logic [TW-1:0] timer_next;
  logic          saiu;
  logic [2:0]    estado_q;

  // Button edge detection. Bit order: {reconhece, parar, liga}.
  // `armed` stays low for the first edge after reset so that a button held
  // through reset release only loads btn_q and never looks like a rise.
  logic [2:0] btn_now;
  logic [2:0] btn_q;
  logic [2:0] press;
  logic       armed;

  assign btn_now = {btn_reconhece, btn_parar, btn_liga};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      btn_q <= 3'b000;
      press <= 3'b000;
      armed <= 1'b0;
    end else begin
      btn_q <= btn_now;
      press <= btn_now & ~btn_q & {3{armed}};
      armed <= 1'b1;
    end
  end

  logic press_liga, press_parar, press_reconhece;
  assign press_liga      = press[0];
  assign press_parar     = press[1];
  assign press_reconhece = press[2];

  // Stage timer: counts cycles spent in the current non-rest main state,
  // minus one (first cycle of a new state loads 0). The timeout fires as
  // the next value reaches TIMEOUT_CYCLES-1, i.e. on the
  // TIMEOUT_CYCLES-th cycle in that state.
  always_comb begin
    timer_next = '0;
    if (estado != estado_q)
      timer_next = '0;
    else if (estado != 3'b000)
      timer_next = timer + TW'(1);
  end

  logic stage_expired;
  assign stage_expired = (estado != 3'b000) && (timer_next == TLIM);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= OCIOSO;
      start    <= 1'b0;
      falha    <= 1'b0;
      timeout  <= 1'b0;
      lotes    <= '0;
      timer    <= '0;
      saiu     <= 1'b0;
      estado_q <= 3'b000;
    end else begin
      estado_q <= estado;
      case (state)
        OCIOSO: begin
          if (press_liga) begin
            state <= ATIVO;
            start <= 1'b1;
            timer <= '0;
            saiu  <= 1'b0;
          end
        end

        ATIVO: begin
          timer <= timer_next;
          if (estado != 3'b000) saiu <= 1'b1;
          if (alarme_in) begin
            state   <= FALHA;
            start   <= 1'b0;
            falha   <= 1'b1;
            timeout <= 1'b0;
          end else if (stage_expired) begin
            state   <= FALHA;
            start   <= 1'b0;
            falha   <= 1'b1;
            timeout <= 1'b1;
          end else if (saiu && (estado == 3'b000)) begin
            // Batch left rest and came back: one completed batch.
            state <= CONCLUIDO;
            start <= 1'b0;
          end else if (press_parar) begin
            state <= PAUSA;
            start <= 1'b0;
          end
        end

        PAUSA: begin
          // Timer and saiu frozen; abort takes precedence over resume.
          if (press_reconhece) begin
            state <= OCIOSO;
            saiu  <= 1'b0;
          end else if (press_liga) begin
            state <= ATIVO;
            start <= 1'b1;
          end
        end

        FALHA: begin
          if (press_reconhece) begin
            state   <= OCIOSO;
            falha   <= 1'b0;
            timeout <= 1'b0;
            timer   <= '0;
            saiu    <= 1'b0;
          end
        end

        CONCLUIDO: begin
          if (lotes != LOTES_MX) lotes <= lotes + BATCH_W'(1);
          state <= OCIOSO;
        end

        default: begin
          state   <= OCIOSO;
          start   <= 1'b0;
          falha   <= 1'b0;
          timeout <= 1'b0;
        end
      endcase
    end
  end

  assign sup_estado = state;

endmodule

// File: tb/tb_mef_supervisor.sv
// Testbench for mef_supervisor (TIMEOUT_CYCLES=8, BATCH_W=4).
// Each cycle: inputs are driven after a falling edge, the expected output
// record is pushed to exp_q, and after the next rising edge the record is
// popped and compared on the falling edge.
module tb_mef_supervisor;

  localparam int W = 10; // {start, falha, timeout, lotes[3:0], sup_estado[2:0]}
  localparam logic [2:0] S_O = 3'b000, S_A = 3'b001, S_P = 3'b010,
                         S_F = 3'b011, S_C = 3'b100;

  // ---------------- clock / reset ----------------
  logic       clock = 1'b0;
  logic       reset_n;
  logic       btn_liga, btn_parar, btn_reconhece, alarme_in;
  logic [2:0] estado;
  logic       start, falha, timeout;
  logic [3:0] lotes;
  logic [2:0] sup_estado;

  always #5 clock = ~clock;

  mef_supervisor #(
    .TIMEOUT_CYCLES(8),
    .TW(10),
    .BATCH_W(4)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .btn_liga(btn_liga),
    .btn_parar(btn_parar),
    .btn_reconhece(btn_reconhece),
    .estado(estado),
    .alarme_in(alarme_in),
    .start(start),
    .falha(falha),
    .timeout(timeout),
    .lotes(lotes),
    .sup_estado(sup_estado)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  task automatic check_pop(input string nm);
    logic [W-1:0] got, exp;
    got = {start, falha, timeout, lotes, sup_estado};
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL %s: no expected record queued, got=%b", nm, got);
    end else begin
      exp = exp_q.pop_front();
      if (got !== exp) begin
        failures++;
        $display("FAIL %s: got start=%b falha=%b timeout=%b lotes=%0d sup=%03b, exp start=%b falha=%b timeout=%b lotes=%0d sup=%03b",
                 nm, got[9], got[8], got[7], got[6:3], got[2:0],
                 exp[9], exp[8], exp[7], exp[6:3], exp[2:0]);
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic cyc(input logic l, input logic p, input logic r,
                     input logic [2:0] e, input logic a,
                     input logic [W-1:0] exp, input string nm);
    btn_liga      = l;
    btn_parar     = p;
    btn_reconhece = r;
    estado        = e;
    alarme_in     = a;
    exp_q.push_back(exp);
    @(posedge clock);
    @(negedge clock);
    check_pop(nm);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       l, p, r;
    logic [2:0] e;
    logic       a;
    logic       st, fa, to;
    logic [3:0] lo;
    logic [2:0] sup;
  } vec_t;

  vec_t tab[$];

  function automatic void add(input logic l, input logic p, input logic r,
                              input logic [2:0] e, input logic a,
                              input logic st, input logic fa, input logic to,
                              input logic [3:0] lo, input logic [2:0] sup);
    vec_t v;
    v.l = l; v.p = p; v.r = r; v.e = e; v.a = a;
    v.st = st; v.fa = fa; v.to = to; v.lo = lo; v.sup = sup;
    tab.push_back(v);
  endfunction

  function automatic logic [W-1:0] pack(input logic st, input logic fa, input logic to,
                                        input logic [3:0] lo, input logic [2:0] sup);
    return {st, fa, to, lo, sup};
  endfunction

  // ---------------- watchdog ----------------
  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- test ----------------
  initial begin
    logic [3:0] prev_l, new_l;

    // Reset release with liga held / press latency
    add(1,0,0,3'd0,0, 0,0,0,4'd0,S_O);
    add(1,0,0,3'd0,0, 0,0,0,4'd0,S_O);
    add(0,0,0,3'd0,0, 0,0,0,4'd0,S_O);
    add(1,0,0,3'd0,0, 0,0,0,4'd0,S_O);
    add(0,0,0,3'd0,0, 1,0,0,4'd0,S_A);
    // Normal batch: 000, 001 x3, 011 x4, 000
    add(0,0,0,3'd0,0, 1,0,0,4'd0,S_A);
    for (int i = 0; i < 3; i++) add(0,0,0,3'd1,0, 1,0,0,4'd0,S_A);
    for (int i = 0; i < 4; i++) add(0,0,0,3'd3,0, 1,0,0,4'd0,S_A);
    add(0,0,0,3'd0,0, 0,0,0,4'd0,S_C);
    add(0,0,0,3'd0,0, 0,0,0,4'd1,S_O);
    // Timeout: estado held at 010, fault on the 8th cycle
    add(1,0,0,3'd0,0, 0,0,0,4'd1,S_O);
    add(0,0,0,3'd0,0, 1,0,0,4'd1,S_A);
    for (int i = 0; i < 7; i++) add(0,0,0,3'd2,0, 1,0,0,4'd1,S_A);
    add(0,0,0,3'd2,0, 0,1,1,4'd1,S_F);
    add(1,0,0,3'd2,0, 0,1,1,4'd1,S_F);
    add(0,0,0,3'd2,0, 0,1,1,4'd1,S_F);
    add(0,1,0,3'd2,0, 0,1,1,4'd1,S_F);
    add(0,0,0,3'd2,0, 0,1,1,4'd1,S_F);
    add(0,0,1,3'd2,0, 0,1,1,4'd1,S_F);
    add(0,0,0,3'd0,0, 0,0,0,4'd1,S_O);
    add(0,0,0,3'd0,1, 0,0,0,4'd1,S_O);
    // Pause / resume: 5 cycles in 001, pause 20+, resume, fault 3 cycles later
    add(1,0,0,3'd0,0, 0,0,0,4'd1,S_O);
    add(0,0,0,3'd0,0, 1,0,0,4'd1,S_A);
    for (int i = 0; i < 3; i++) add(0,0,0,3'd1,0, 1,0,0,4'd1,S_A);
    add(0,1,0,3'd1,0, 1,0,0,4'd1,S_A);
    add(0,0,0,3'd1,0, 0,0,0,4'd1,S_P);
    for (int i = 0; i < 20; i++) add(0,0,0,3'd1,0, 0,0,0,4'd1,S_P);
    add(1,0,0,3'd1,0, 0,0,0,4'd1,S_P);
    add(0,0,0,3'd1,0, 1,0,0,4'd1,S_A);
    add(0,0,0,3'd1,0, 1,0,0,4'd1,S_A);
    add(0,0,0,3'd1,0, 1,0,0,4'd1,S_A);
    add(0,0,0,3'd1,0, 0,1,1,4'd1,S_F);
    add(0,0,1,3'd1,0, 0,1,1,4'd1,S_F);
    add(0,0,0,3'd0,0, 0,0,0,4'd1,S_O);
    // Alarm on the same cycle the timer reaches its limit
    add(1,0,0,3'd0,0, 0,0,0,4'd1,S_O);
    add(0,0,0,3'd0,0, 1,0,0,4'd1,S_A);
    for (int i = 0; i < 7; i++) add(0,0,0,3'd1,0, 1,0,0,4'd1,S_A);
    add(0,0,0,3'd1,1, 0,1,0,4'd1,S_F);
    add(0,0,1,3'd1,0, 0,1,0,4'd1,S_F);
    add(0,0,0,3'd0,0, 0,0,0,4'd1,S_O);
    // liga + parar together in ATIVO -> PAUSA
    add(1,0,0,3'd0,0, 0,0,0,4'd1,S_O);
    add(0,0,0,3'd0,0, 1,0,0,4'd1,S_A);
    add(1,1,0,3'd1,0, 1,0,0,4'd1,S_A);
    add(0,0,0,3'd1,0, 0,0,0,4'd1,S_P);
    // Abort: liga + reconhece in PAUSA -> OCIOSO, lotes unchanged
    add(1,0,1,3'd1,0, 0,0,0,4'd1,S_P);
    add(0,0,0,3'd1,0, 0,0,0,4'd1,S_O);
    add(1,0,0,3'd0,0, 0,0,0,4'd1,S_O);
    add(0,0,0,3'd0,0, 1,0,0,4'd1,S_A);
    add(0,0,0,3'd0,0, 1,0,0,4'd1,S_A);
    add(0,0,0,3'd0,0, 1,0,0,4'd1,S_A);
    add(0,0,0,3'd1,0, 1,0,0,4'd1,S_A);
    add(0,0,0,3'd0,0, 0,0,0,4'd1,S_C);
    add(0,0,0,3'd0,0, 0,0,0,4'd2,S_O);

    // Reset asserted with liga held
    reset_n = 1'b0; btn_liga = 1'b1; btn_parar = 1'b0; btn_reconhece = 1'b0;
    estado = 3'd0; alarme_in = 1'b0;
    #12;
    exp_q.push_back(pack(0,0,0,4'd0,S_O));
    check_pop("reset_state");
    @(negedge clock);
    reset_n = 1'b1;

    for (int i = 0; i < tab.size(); i++)
      cyc(tab[i].l, tab[i].p, tab[i].r, tab[i].e, tab[i].a,
          pack(tab[i].st, tab[i].fa, tab[i].to, tab[i].lo, tab[i].sup),
          $sformatf("vec[%0d]", i));

    // Batches 3..16: lotes saturates at 15
    prev_l = 4'd2;
    for (int b = 3; b <= 16; b++) begin
      new_l = (prev_l == 4'd15) ? 4'd15 : prev_l + 4'd1;
      cyc(1,0,0,3'd0,0, pack(0,0,0,prev_l,S_O), $sformatf("batch%0d_press", b));
      cyc(0,0,0,3'd0,0, pack(1,0,0,prev_l,S_A), $sformatf("batch%0d_run", b));
      cyc(0,0,0,3'd1,0, pack(1,0,0,prev_l,S_A), $sformatf("batch%0d_busy", b));
      cyc(0,0,0,3'd0,0, pack(0,0,0,prev_l,S_C), $sformatf("batch%0d_done", b));
      cyc(0,0,0,3'd0,0, pack(0,0,0,new_l,S_O),  $sformatf("batch%0d_count", b));
      prev_l = new_l;
    end

    // Asynchronous reset mid-operation
    cyc(1,0,0,3'd0,0, pack(0,0,0,4'd15,S_O), "midrst_press");
    cyc(1,0,0,3'd1,0, pack(1,0,0,4'd15,S_A), "midrst_run");
    #2;
    reset_n = 1'b0;
    #1;
    exp_q.push_back(pack(0,0,0,4'd0,S_O));
    check_pop("midrst_async");
    @(negedge clock);
    reset_n = 1'b1;
    cyc(1,0,0,3'd0,0, pack(0,0,0,4'd0,S_O), "midrst_hold1");
    cyc(1,0,0,3'd0,0, pack(0,0,0,4'd0,S_O), "midrst_hold2");

    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain: %0d records left, expected 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mef_supervisor.md
Name: mef_supervisor

Overview:
- Supervisory sequencer sitting above the main process state machine.
- Converts operator buttons into the main FSM's `start` enable.
  - The main FSM holds its state whenever `start`=0.
- Watches the main FSM state code `estado[2:0]` and its `alarme_in` output.
- Enforces a per-stage timeout, latches faults until acknowledged, and counts completed batches.

Parameters:
- TIMEOUT_CYCLES, 1000: max clock cycles the main FSM may stay in one non-rest state before a timeout fault. Legal range 2..2^TW-1.
- TW, 10: width of the stage timer.
- BATCH_W, 4: width of the completed-batch counter.

Ports:
- clock  in  1  system clock; all flops rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- btn_liga  in  1  operator run/resume request; level, synchronous to clock.
- btn_parar  in  1  operator pause request; level.
- btn_reconhece  in  1  operator fault acknowledge / abort; level.
- estado  in  3  main FSM state code; 3'b000 is its rest state.
- alarme_in  in  1  alarm output of the main FSM.
- start  out  1  enable to the main FSM.
- falha  out  1  latched fault indicator.
- timeout  out  1  fault cause is stage timeout. Valid only while falha=1.
- lotes  out  BATCH_W  completed batch count, saturating.
- sup_estado  out  3  current supervisor state code, for display.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - State goes to OCIOSO.
  - start=0, falha=0, timeout=0, lotes=0, sup_estado=000.
  - Timer, `saiu` flag, previous-estado register and button edge registers all cleared.
- Button edge detection:
  - Each button is registered once per cycle. A "press" is a rising edge: current=1 and registered=0.
  - Holding a button generates exactly one press.
  - A button held through reset release does not generate a press.
- State encoding: OCIOSO=000, ATIVO=001, PAUSA=010, FALHA=011, CONCLUIDO=100. All unused codes go to OCIOSO.
- start=1 only in ATIVO. falha=1 only in FALHA.
- OCIOSO:
  - Press liga -> ATIVO. Timer=0, saiu=0.
  - All other inputs ignored; alarme_in ignored.
- ATIVO:
  - Timer:
    - estado != registered previous estado -> timer=0.
    - Otherwise, estado != 000 -> timer+1.
    - estado=000 -> timer held at 0.
  - saiu set the first cycle estado != 000.
  - Exit priority, highest first, evaluated each cycle:
    1. alarme_in=1 -> FALHA, timeout=0.
    2. estado != 000 and timer == TIMEOUT_CYCLES-1 -> FALHA, timeout=1.
    3. saiu=1 and estado=000 (batch returned to rest) -> CONCLUIDO.
    4. Press parar -> PAUSA.
- PAUSA:
  - start=0; timer and saiu frozen.
  - Press liga -> ATIVO; the timer resumes from its frozen value.
  - Press reconhece -> OCIOSO (abort): saiu=0, lotes unchanged.
  - Press liga and press reconhece in the same cycle -> reconhece wins.
- FALHA:
  - start=0; falha and timeout latched.
  - Only a press of reconhece leaves: -> OCIOSO, falha=0, timeout=0, timer=0, saiu=0.
  - liga and parar are ignored.
- CONCLUIDO:
  - Lasts exactly one cycle, start=0.
  - lotes+1, saturating at 2^BATCH_W-1 (no wrap).
  - Then unconditionally -> OCIOSO.
- Simultaneous presses of liga and parar:
  - In OCIOSO, liga acts.
  - In ATIVO, parar acts.
  - In PAUSA, liga acts.
- The timer never exceeds TIMEOUT_CYCLES-1; it saturates there only as the FALHA transition fires.
- Latency: a button press is seen on start the cycle after the edge register samples it, i.e. 2 clock edges from the input rise.
- Reset mid-operation: immediate return to reset values. lotes is lost.

Test Plan:
- Reset release with btn_liga held at 1 -> stays OCIOSO, start=0. Release, then press liga -> start=1 two edges after the rise, sup_estado=001.
- Normal batch with TIMEOUT_CYCLES=8:
  - Stimulus: ATIVO; estado sequence 000, 001 (3 cycles), 011 (4 cycles), 000.
  - Response: one cycle of sup_estado=100 with start=0, then OCIOSO, lotes=1.
  - Repeat 16 times with BATCH_W=4 -> lotes saturates at 15.
- Timeout: TIMEOUT_CYCLES=8; estado held at 010 in ATIVO -> after the 8th cycle in 010, sup_estado=011, falha=1, timeout=1, start=0. liga press ignored. reconhece press -> OCIOSO, falha=0, timeout=0.
- Pause/resume:
  - Stimulus: estado held at 001 for 5 cycles, press parar, stay in PAUSA 20 cycles, press liga.
  - Response: start=0 throughout PAUSA; timeout fires 3 cycles after resume, not earlier.
- Alarm plus simultaneous events:
  - alarme_in=1 on the same cycle the timer hits its limit -> FALHA with timeout=0.
  - In ATIVO, liga and parar pressed together -> PAUSA.
- Abort: in PAUSA press liga and reconhece together -> OCIOSO, lotes unchanged, saiu cleared. Next run: a first estado=000 cycle does not produce CONCLUIDO.
